// File: rtl/ace_snoop_responder_pkg.sv
// ace_snoop_responder_pkg: snoop encodings, CRRESP bit indices, channel structs and response helpers
// shared by the ACE snoop responder.
package ace_snoop_responder_pkg;
  localparam int AxiAddrWidth    = 64;
  localparam int AxiDataWidth    = 64;
  localparam int DcacheLineWidth = 128;
  localparam int NoBeats         = DcacheLineWidth / AxiDataWidth;
  localparam int BeatWidth       = NoBeats > 1 ? $clog2(NoBeats) : 1;
  localparam int LineOffWidth    = $clog2(DcacheLineWidth / 8);

  localparam logic [3:0] SNP_READ_ONCE              = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED            = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN             = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY  = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE            = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED           = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID          = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID           = 4'b1101;

  localparam int CR_DATA_TRANSFER = 0;
  localparam int CR_ERROR         = 1;
  localparam int CR_PASS_DIRTY    = 2;
  localparam int CR_IS_SHARED     = 3;
  localparam int CR_WAS_UNIQUE    = 4;

  typedef enum logic [1:0] {UPD_NONE, UPD_CLEAN, UPD_SHARE, UPD_INVAL} snp_upd_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_WAIT, ST_CR, ST_CD, ST_UPD} state_e;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] addr;
    logic [3:0]              snoop;
  } ac_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic                    last;
  } cd_chan_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

  function automatic logic snp_supported(input logic [3:0] s);
    return s inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY,
                     SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID};
  endfunction

  function automatic logic [4:0] snp_crresp(input logic [3:0] s, input logic hit, dirty, shared);
    logic [2:0] dt_is_pd;
    dt_is_pd = 3'b000;
    case (s)
      SNP_READ_ONCE:                                               dt_is_pd = 3'b110;
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY:  dt_is_pd = {2'b11, dirty};
      SNP_READ_UNIQUE, SNP_CLEAN_INVALID:                          dt_is_pd = {2'b10, dirty};
      SNP_CLEAN_SHARED:                                            dt_is_pd = {dirty, 1'b1, dirty};
      default:                                                     dt_is_pd = 3'b000;
    endcase
    return hit ? {~shared, dt_is_pd[1], dt_is_pd[0], 1'b0, dt_is_pd[2]} : 5'b00000;
  endfunction

  function automatic snp_upd_e snp_updop(input logic [3:0] s, input logic hit);
    snp_upd_e op;
    op = UPD_NONE;
    case (s)
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY: op = UPD_SHARE;
      SNP_READ_UNIQUE, SNP_CLEAN_INVALID, SNP_MAKE_INVALID:       op = UPD_INVAL;
      SNP_CLEAN_SHARED:                                           op = UPD_CLEAN;
      default:                                                    op = UPD_NONE;
    endcase
    return hit ? op : UPD_NONE;
  endfunction
endpackage

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: cache-side ACE snoop responder (AC -> lookup -> CR -> CD burst -> line update).
// ACE_SNOOP_AC_PREFETCH_EN adds a 1-entry AC buffer so a snoop can be accepted while one is in flight.
module ace_snoop_responder
  import ace_snoop_responder_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  snoop_req_t                  snoop_req_i,
  output snoop_resp_t                 snoop_resp_o,
  output logic                        lkp_valid_o,
  input  logic                        lkp_ready_i,
  output logic [AxiAddrWidth-1:0]     lkp_addr_o,
  input  logic                        lkp_rvalid_i,
  input  logic                        lkp_hit_i,
  input  logic                        lkp_dirty_i,
  input  logic                        lkp_shared_i,
  input  logic [DcacheLineWidth-1:0]  lkp_data_i,
  output logic                        upd_valid_o,
  input  logic                        upd_ready_i,
  output snp_upd_e                    upd_op_o
);
  state_e                              state_q;
  logic                                ac_ready_q, lkp_valid_q, cr_valid_q, cd_valid_q, upd_valid_q;
  logic [4:0]                          cr_resp_q;
  snp_upd_e                            op_q;
  logic [3:0]                          snoop_q;
  logic [AxiAddrWidth-1:LineOffWidth]  addr_q;
  logic [DcacheLineWidth-1:0]          line_q;
  logic [BeatWidth-1:0]                beat_q;
  ac_chan_t                            src;
  logic                                ac_hs, upd_done, take, have, start, ac_ready_d, cd_last;
  logic                                unused_addr_lo;

  assign ac_hs    = snoop_req_i.ac_valid & ac_ready_q;
  assign upd_done = (state_q == ST_UPD) & (upd_ready_i | (op_q == UPD_NONE));
  assign take     = (state_q == ST_IDLE) | upd_done;
  assign start    = take & have;
  assign cd_last  = beat_q == BeatWidth'(NoBeats - 1);
  assign unused_addr_lo = ^src.addr[LineOffWidth-1:0];

`ifdef ACE_SNOOP_AC_PREFETCH_EN
  ac_chan_t buf_q;
  logic     buf_full_q;
  assign src        = buf_full_q ? buf_q : snoop_req_i.ac;
  assign have       = buf_full_q | ac_hs;
  assign ac_ready_d = start | ~have;
  // A snoop arriving while nothing can start is parked; a waiting one starts without an IDLE cycle.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      buf_full_q <= ~start & have;
      if (ac_hs & ~start) buf_q <= snoop_req_i.ac;
    end
`else
  assign src        = snoop_req_i.ac;
  assign have       = ac_hs;
  assign ac_ready_d = take & ~start;
`endif

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ac_ready_q  <= 1'b0;
      lkp_valid_q <= 1'b0;
      cr_valid_q  <= 1'b0;
      cd_valid_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      cr_resp_q   <= '0;
      op_q        <= UPD_NONE;
      snoop_q     <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      beat_q      <= '0;
    end else begin
      ac_ready_q <= ac_ready_d;
      if (start) begin
        snoop_q     <= src.snoop;
        addr_q      <= src.addr[AxiAddrWidth-1:LineOffWidth];
        upd_valid_q <= 1'b0;
        if (snp_supported(src.snoop)) begin
          state_q     <= ST_LOOKUP;
          lkp_valid_q <= 1'b1;
        end else begin
          state_q    <= ST_CR;
          cr_valid_q <= 1'b1;
          cr_resp_q  <= 5'(1 << CR_ERROR);
          op_q       <= UPD_NONE;
        end
      end else begin
        case (state_q)
          ST_LOOKUP: if (lkp_ready_i) begin
            lkp_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
          ST_WAIT: if (lkp_rvalid_i) begin
            line_q     <= lkp_data_i;
            cr_resp_q  <= snp_crresp(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_shared_i);
            op_q       <= snp_updop(snoop_q, lkp_hit_i);
            cr_valid_q <= 1'b1;
            state_q    <= ST_CR;
          end
          ST_CR: if (snoop_req_i.cr_ready) begin
            cr_valid_q  <= 1'b0;
            cd_valid_q  <= cr_resp_q[CR_DATA_TRANSFER];
            upd_valid_q <= ~cr_resp_q[CR_DATA_TRANSFER] & (op_q != UPD_NONE);
            state_q     <= cr_resp_q[CR_DATA_TRANSFER] ? ST_CD : ST_UPD;
          end
          ST_CD: if (snoop_req_i.cd_ready) begin
            beat_q      <= cd_last ? '0 : beat_q + 1'b1;
            cd_valid_q  <= ~cd_last;
            upd_valid_q <= cd_last & (op_q != UPD_NONE);
            state_q     <= cd_last ? ST_UPD : ST_CD;
          end
          ST_UPD: if (upd_done) begin
            upd_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end

  assign snoop_resp_o.ac_ready = ac_ready_q;
  assign snoop_resp_o.cr_valid = cr_valid_q;
  assign snoop_resp_o.cr_resp  = cr_resp_q;
  assign snoop_resp_o.cd_valid = cd_valid_q;
  assign snoop_resp_o.cd.data  = line_q[beat_q*AxiDataWidth +: AxiDataWidth];
  assign snoop_resp_o.cd.last  = cd_last;
  assign lkp_valid_o           = lkp_valid_q;
  assign lkp_addr_o            = {addr_q, LineOffWidth'(0)};
  assign upd_valid_o           = upd_valid_q;
  assign upd_op_o              = op_q;
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed self-checking bench for ace_snoop_responder
// (the prefetch scenario is exercised when ACE_SNOOP_AC_PREFETCH_EN is defined).
module tb_ace_snoop_responder;
  import ace_snoop_responder_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  snoop_req_t   req;
  snoop_resp_t  resp;
  logic         lkp_valid_o, lkp_ready_i, lkp_rvalid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i;
  logic [63:0]  lkp_addr_o;
  logic [127:0] lkp_data_i;
  logic         upd_valid_o, upd_ready_i;
  snp_upd_e     upd_op_o;
  int           passed = 0, total = 0;

  localparam logic [127:0] LINE_A = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
  localparam logic [127:0] LINE_B = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};

  always #5 clk_i = ~clk_i;

  ace_snoop_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .snoop_req_i(req), .snoop_resp_o(resp),
    .lkp_valid_o(lkp_valid_o), .lkp_ready_i(lkp_ready_i), .lkp_addr_o(lkp_addr_o),
    .lkp_rvalid_i(lkp_rvalid_i), .lkp_hit_i(lkp_hit_i), .lkp_dirty_i(lkp_dirty_i),
    .lkp_shared_i(lkp_shared_i), .lkp_data_i(lkp_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_op_o(upd_op_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_ac(input logic [63:0] addr, input logic [3:0] snp);
    int n = 0;
    req.ac.addr  = addr;
    req.ac.snoop = snp;
    req.ac_valid = 1'b1;
    while (!resp.ac_ready && n < 20) begin
      tick;
      n++;
    end
    chk("ac_ready_wait", n < 20, 1);
    tick;
    req.ac_valid = 1'b0;
  endtask

  task automatic serve_lookup(input logic [63:0] exp_addr, input logic hit, dirty, shared,
                              input logic [127:0] data);
    int n = 0;
    while (!lkp_valid_o && n < 20) begin
      tick;
      n++;
    end
    chk("lkp_valid_wait", n < 20, 1);
    chk("lkp_addr", lkp_addr_o, exp_addr);
    lkp_ready_i = 1'b1;
    tick;
    lkp_ready_i = 1'b0;
    chk("lkp_valid_drop", lkp_valid_o, 0);
    chk("cr_early", resp.cr_valid, 0);
    tick;
    lkp_rvalid_i = 1'b1;
    lkp_hit_i    = hit;
    lkp_dirty_i  = dirty;
    lkp_shared_i = shared;
    lkp_data_i   = data;
    tick;
    lkp_rvalid_i = 1'b0;
    lkp_data_i   = '0;
  endtask

  task automatic do_cr(input logic [4:0] exp);
    chk("cr_valid", resp.cr_valid, 1);
    chk("cr_resp", resp.cr_resp, exp);
    tick;
    chk("cr_hold_valid", resp.cr_valid, 1);
    chk("cr_hold_resp", resp.cr_resp, exp);
    chk("cd_before_cr", resp.cd_valid, 0);
    req.cr_ready = 1'b1;
    tick;
    req.cr_ready = 1'b0;
    chk("cr_drop", resp.cr_valid, 0);
  endtask

  task automatic do_cd(input logic [127:0] line, input int stall);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < stall; s++) begin
        chk("cd_stall_valid", resp.cd_valid, 1);
        chk("cd_stall_data", resp.cd.data, line[k*64 +: 64]);
        chk("cd_stall_last", resp.cd.last, k == 1);
        tick;
      end
      chk("cd_valid", resp.cd_valid, 1);
      chk("cd_data", resp.cd.data, line[k*64 +: 64]);
      chk("cd_last", resp.cd.last, k == 1);
      req.cd_ready = 1'b1;
      tick;
      req.cd_ready = 1'b0;
    end
    chk("cd_drop", resp.cd_valid, 0);
  endtask

  task automatic do_upd(input snp_upd_e op);
    chk("no_cd", resp.cd_valid, 0);
    if (op == UPD_NONE) begin
      chk("upd_none_valid", upd_valid_o, 0);
      tick;
    end else begin
      chk("upd_valid", upd_valid_o, 1);
      chk("upd_op", upd_op_o, op);
      tick;
      chk("upd_hold", upd_valid_o, 1);
      upd_ready_i = 1'b1;
      tick;
      upd_ready_i = 1'b0;
    end
    chk("upd_drop", upd_valid_o, 0);
    chk("idle_ac_ready", resp.ac_ready, 1);
  endtask

  initial begin
    req = '0;
    lkp_ready_i = 0; lkp_rvalid_i = 0; lkp_hit_i = 0; lkp_dirty_i = 0; lkp_shared_i = 0;
    lkp_data_i = '0; upd_ready_i = 0;
    tick;
    tick;
    chk("rst_ac_ready", resp.ac_ready, 0);
    chk("rst_cr_valid", resp.cr_valid, 0);
    chk("rst_cr_resp", resp.cr_resp, 0);
    chk("rst_cd_valid", resp.cd_valid, 0);
    chk("rst_cd_data", resp.cd.data, 0);
    chk("rst_lkp_valid", lkp_valid_o, 0);
    chk("rst_upd_valid", upd_valid_o, 0);
    rst_ni = 1'b1;
    tick;
    chk("idle_ready", resp.ac_ready, 1);

    send_ac(64'h0000_0000_1234_5678, SNP_READ_SHARED);
    chk("ac_ready_busy", resp.ac_ready, 0);
    serve_lookup(64'h0000_0000_1234_5670, 1, 0, 0, LINE_A);
    do_cr(5'b11001);
    do_cd(LINE_A, 0);
    do_upd(UPD_SHARE);

    send_ac(64'h0000_0000_0000_ABCF, SNP_READ_UNIQUE);
    serve_lookup(64'h0000_0000_0000_ABC0, 1, 1, 0, LINE_B);
    do_cr(5'b10101);
    do_cd(LINE_B, 3);
    do_upd(UPD_INVAL);

    send_ac(64'h0000_0000_0000_1000, SNP_CLEAN_SHARED);
    serve_lookup(64'h0000_0000_0000_1000, 1, 0, 1, LINE_A);
    do_cr(5'b01000);
    do_upd(UPD_CLEAN);

    send_ac(64'h0000_0000_0000_2008, SNP_MAKE_INVALID);
    serve_lookup(64'h0000_0000_0000_2000, 0, 1, 0, LINE_A);
    do_cr(5'b00000);
    do_upd(UPD_NONE);

    send_ac(64'h0000_0000_0000_3000, 4'b1111);
    chk("bad_no_lkp", lkp_valid_o, 0);
    do_cr(5'b00010);
    chk("bad_no_lkp2", lkp_valid_o, 0);
    do_upd(UPD_NONE);
    chk("bad_no_lkp3", lkp_valid_o, 0);

    send_ac(64'h0000_0000_0000_4000, SNP_READ_ONCE);
    serve_lookup(64'h0000_0000_0000_4000, 1, 0, 0, LINE_B);
    do_cr(5'b11001);
    chk("rst_cd_beat0", resp.cd_valid, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_cd_valid", resp.cd_valid, 0);
    chk("arst_cr_valid", resp.cr_valid, 0);
    chk("arst_lkp_valid", lkp_valid_o, 0);
    chk("arst_upd_valid", upd_valid_o, 0);
    chk("arst_ac_ready", resp.ac_ready, 0);
    rst_ni = 1'b1;
    tick;
    send_ac(64'h0000_0000_0000_5000, SNP_READ_ONCE);
    serve_lookup(64'h0000_0000_0000_5000, 1, 0, 0, LINE_A);
    do_cr(5'b11001);
    do_cd(LINE_A, 1);
    do_upd(UPD_NONE);

`ifdef ACE_SNOOP_AC_PREFETCH_EN
    send_ac(64'h0000_0000_0000_6000, SNP_READ_SHARED);
    serve_lookup(64'h0000_0000_0000_6000, 1, 0, 0, LINE_B);
    do_cr(5'b11001);
    req.ac.addr  = 64'h0000_0000_0000_7000;
    req.ac.snoop = SNP_MAKE_INVALID;
    req.ac_valid = 1'b1;
    chk("pf_ready_in_cd", resp.ac_ready, 1);
    tick;
    req.ac_valid = 1'b0;
    chk("pf_buf_full", resp.ac_ready, 0);
    chk("pf_no_lkp_yet", lkp_valid_o, 0);
    do_cd(LINE_B, 0);
    do_upd(UPD_SHARE);
    chk("pf_lkp_after_upd", lkp_valid_o, 1);
    serve_lookup(64'h0000_0000_0000_7000, 0, 0, 0, LINE_A);
    do_cr(5'b00000);
    do_upd(UPD_NONE);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
